alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 16 +
 rtl/alu_arbiter_if.sv | 51 +++++
 rtl/alu_rr_pick.sv | 19 +
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// State encoding, multu control code and default widths live here.
package alu_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 6;

    localparam logic [5:0] CTRL_MULTU = 6'h13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the external ALU.
// slave = arbiter side, master = requesters plus ALU side.
interface alu_arbiter_if
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
);

    // Handshake rule: a request (or response) transfers on a rising edge where
    // its valid and ready are both high; the sender holds valid and payload
    // stable until that edge, and ready seen while valid is low has no effect.
    logic              req0_valid, req0_ready;
    logic [CTRL_W-1:0] req0_ctrl;
    logic [DATA_W-1:0] req0_a, req0_b;

    logic              req1_valid, req1_ready;
    logic [CTRL_W-1:0] req1_ctrl;
    logic [DATA_W-1:0] req1_a, req1_b;

    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [DATA_W-1:0] alu_r, alu_r2;
    logic              alu_z;

    logic              rsp0_valid, rsp0_ready;
    logic              rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp_r, rsp_r2;
    logic              rsp_z;

    modport slave (
        input  req0_valid, req0_ctrl, req0_a, req0_b,
        input  req1_valid, req1_ctrl, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_ctrl, alu_a, alu_b,
        input  alu_r, alu_r2, alu_z,
        output rsp0_valid, rsp1_valid, rsp_r, rsp_r2, rsp_z,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_ctrl, req0_a, req0_b,
        output req1_valid, req1_ctrl, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_ctrl, alu_a, alu_b,
        output alu_r, alu_r2, alu_z,
        input  rsp0_valid, rsp1_valid, rsp_r, rsp_r2, rsp_z,
        output rsp0_ready, rsp1_ready
    );

endinterface

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: a lone request wins; on a tie the requester
// that was not granted last wins. Grant is one-hot (or zero).
module alu_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared external combinational ALU.
// Build option ALU_ARB_MULT2_EN: multu (CTRL_MULTU) spends two cycles in EXEC.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus,
    output state_e       dbg_state
);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              gnt_id_q, gnt_id_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] rsp_r_q, rsp_r_d, rsp_r2_q, rsp_r2_d;
    logic              rsp_z_q, rsp_z_d;
    logic [1:0]        req_vec, pick;
    logic              exec_last;

    // Masking with rst keeps every ready low while reset is held.
    assign req_vec = {bus.req1_valid, bus.req0_valid} & {2{rst}};

    alu_rr_pick u_pick (
        .req  (req_vec),
        .last (last_q),
        .gnt  (pick)
    );

`ifdef ALU_ARB_MULT2_EN
    logic ext_q, ext_d;
    assign exec_last = (ctrl_q != CTRL_W'(CTRL_MULTU)) || ext_q;
`else
    assign exec_last = 1'b1;
`endif

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        gnt_id_d       = gnt_id_q;
        ctrl_d         = ctrl_q;
        a_d            = a_q;
        b_d            = b_q;
        rsp_r_d        = rsp_r_q;
        rsp_r2_d       = rsp_r2_q;
        rsp_z_d        = rsp_z_q;
`ifdef ALU_ARB_MULT2_EN
        ext_d          = 1'b0;
`endif
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.alu_ctrl   = '0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    bus.req0_ready = pick[0];
                    bus.req1_ready = pick[1];
                    gnt_id_d       = pick[1];
                    last_d         = pick[1];
                    ctrl_d         = pick[1] ? bus.req1_ctrl : bus.req0_ctrl;
                    a_d            = pick[1] ? bus.req1_a    : bus.req0_a;
                    b_d            = pick[1] ? bus.req1_b    : bus.req0_b;
                    state_d        = ST_EXEC;
                end
            end
            ST_EXEC: begin
                bus.alu_ctrl = ctrl_q;
                bus.alu_a    = a_q;
                bus.alu_b    = b_q;
                if (exec_last) begin
                    rsp_r_d  = bus.alu_r;
                    rsp_r2_d = bus.alu_r2;
                    rsp_z_d  = bus.alu_z;
                    state_d  = ST_RESP;
                end
`ifdef ALU_ARB_MULT2_EN
                ext_d = ~exec_last;
`endif
            end
            ST_RESP: begin
                bus.rsp0_valid = ~gnt_id_q;
                bus.rsp1_valid = gnt_id_q;
                if (gnt_id_q ? bus.rsp1_ready : bus.rsp0_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_q resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            gnt_id_q <= 1'b0;
            ctrl_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rsp_r_q  <= '0;
            rsp_r2_q <= '0;
            rsp_z_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_id_q <= gnt_id_d;
            ctrl_q   <= ctrl_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rsp_r_q  <= rsp_r_d;
            rsp_r2_q <= rsp_r2_d;
            rsp_z_q  <= rsp_z_d;
        end
    end

`ifdef ALU_ARB_MULT2_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ext_q <= 1'b0;
        else      ext_q <= ext_d;
    end
`endif

    assign bus.rsp_r  = rsp_r_q;
    assign bus.rsp_r2 = rsp_r2_q;
    assign bus.rsp_z  = rsp_z_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written corner sequences
// and a randomized run against a cycle-level transaction model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int DW = 32;
    localparam int CW = 6;
`ifdef ALU_ARB_MULT2_EN
    localparam int MULT_LAT = 3;
`else
    localparam int MULT_LAT = 2;
`endif

    typedef struct {
        int            id;
        logic [CW-1:0] c;
        logic [DW-1:0] a, b, r, r2;
        logic          z;
        int            lat;
    } vec_t;

    logic   clk;
    logic   rst;
    state_e dbg_state;
    int     checks   = 0;
    int     failures = 0;

    alu_arbiter_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

    alu_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: and/or/xor/add/sub, multu, anything else gives r=0.
    function automatic logic [2*DW:0] alu_fn(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [DW-1:0]   r, r2;
        logic [2*DW-1:0] p;
        r  = '0;
        r2 = '0;
        p  = '0;
        case (c)
            6'h00: r = a & b;
            6'h01: r = a | b;
            6'h02: r = a ^ b;
            6'h03: r = a + b;
            6'h04: r = a - b;
            CTRL_MULTU: begin
                p  = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
                r  = p[DW-1:0];
                r2 = p[2*DW-1:DW];
            end
            default: ;
        endcase
        return {(r == '0), r2, r};
    endfunction

    always_comb {bus.alu_z, bus.alu_r2, bus.alu_r} = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic rv(input int id);
        return (id == 1) ? bus.rsp1_valid : bus.rsp0_valid;
    endfunction

    function automatic logic [2*DW:0] rsp_word();
        return {bus.rsp_z, bus.rsp_r2, bus.rsp_r};
    endfunction

    task automatic set_req(input int id, input logic v, input logic [CW-1:0] c,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (id == 1) begin
            bus.req1_valid = v; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic set_rsp_rdy(input int id, input logic v);
        if (id == 1) bus.rsp1_ready = v;
        else         bus.rsp0_ready = v;
    endtask

    task automatic idle_inputs();
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        set_rsp_rdy(0, 1'b0);
        set_rsp_rdy(1, 1'b0);
    endtask

    // Called at the sample point of the capture cycle; returns cycles until rspN_valid.
    task automatic wait_rsp(input int id, output int lat);
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) set_req(id, 1'b0, '0, '0, '0);
            #1;
            if (rv(id)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic consume(input int id);
        set_rsp_rdy(id, 1'b1);
        @(negedge clk);
        set_rsp_rdy(id, 1'b0);
        #1;
    endtask

    task automatic single_op(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        set_req(v.id, 1'b1, v.c, v.a, v.b);
        #1;
        chk($sformatf("vec%0d_ready", idx), {bus.req1_ready, bus.req0_ready},
            (v.id == 1) ? 2'b10 : 2'b01);
        wait_rsp(v.id, lat);
        chk($sformatf("vec%0d_latency", idx), lat, v.lat);
        chk($sformatf("vec%0d_other_valid", idx), rv(1 - v.id), 1'b0);
        chk($sformatf("vec%0d_result", idx), rsp_word(), {v.z, v.r2, v.r});
        consume(v.id);
        chk($sformatf("vec%0d_after", idx), {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
    endtask

    function automatic logic [CW-1:0] rand_ctrl();
        int sel;
        sel = $urandom_range(0, 6);
        if (sel <= 4) return CW'(sel);
        if (sel == 5) return CTRL_MULTU;
        return CW'($urandom_range(0, 63));
    endfunction

    // Transaction-level model: one op in flight; ALU driven for lat-1 cycles
    // after capture, then the owner's response until it is taken.
    task automatic run_random(input int n_cycles);
        logic [2*DW:0] exp_q[$];
        logic          pv[2];
        logic [CW-1:0] pc[2];
        logic [DW-1:0] pa[2], pb[2];
        logic [1:0]    rr, exp_rdy, exp_rv;
        logic [69:0]   exp_alu;
        logic [CW-1:0] gc;
        logic [DW-1:0] ga, gb;
        bit            busy;
        int            cap, gid, glat, last, win;
        pv   = '{1'b0, 1'b0};
        busy = 1'b0;
        last = 1;
        cap  = 0; gid = 0; glat = 2;
        gc = '0; ga = '0; gb = '0;
        for (int cyc = 0; cyc < n_cycles; cyc++) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if (!pv[n] && $urandom_range(0, 2) == 0) begin
                    pv[n] = 1'b1;
                    pc[n] = rand_ctrl();
                    pa[n] = $urandom;
                    pb[n] = ($urandom_range(0, 3) == 0) ? pa[n] : $urandom;
                end
                set_req(n, pv[n], pc[n], pa[n], pb[n]);
                rr[n] = 1'($urandom_range(0, 1));
                set_rsp_rdy(n, rr[n]);
            end
            #1;
            win = -1;
            if (!busy) begin
                if (pv[0] && pv[1]) win = (last == 1) ? 0 : 1;
                else if (pv[0])     win = 0;
                else if (pv[1])     win = 1;
            end
            exp_rdy = 2'b00;
            if (win >= 0) exp_rdy[win] = 1'b1;
            exp_alu = '0;
            exp_rv  = 2'b00;
            if (busy) begin
                if (cyc - cap < glat) exp_alu = {gc, ga, gb};
                else                  exp_rv[gid] = 1'b1;
            end
            chk("rnd_ready", {bus.req1_ready, bus.req0_ready}, exp_rdy);
            chk("rnd_alu", {bus.alu_ctrl, bus.alu_a, bus.alu_b}, exp_alu);
            chk("rnd_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, exp_rv);
            if (exp_rv != 2'b00) begin
                chk("rnd_result", rsp_word(), exp_q[0]);
                if (rr[gid]) begin
                    void'(exp_q.pop_front());
                    busy = 1'b0;
                end
            end
            if (win >= 0) begin
                busy = 1'b1;
                cap  = cyc;
                gid  = win;
                gc   = pc[win];
                ga   = pa[win];
                gb   = pb[win];
                glat = (pc[win] == CTRL_MULTU) ? MULT_LAT : 2;
                exp_q.push_back(alu_fn(gc, ga, gb));
                last = win;
                pv[win] = 1'b0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        vec_t vecs[7];
        int   lat;
        logic seen;
        vecs[0] = '{0, 6'h03, 32'd5,         32'd7,         32'd12,        32'd0, 1'b0, 2};
        vecs[1] = '{1, 6'h04, 32'd10,        32'd10,        32'd0,         32'd0, 1'b1, 2};
        vecs[2] = '{0, 6'h02, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 2};
        vecs[3] = '{1, 6'h13, 32'h0001_0000, 32'h0001_0000, 32'd0,         32'd1, 1'b1, MULT_LAT};
        vecs[4] = '{0, 6'h3F, 32'd1,         32'd1,         32'd0,         32'd0, 1'b1, 2};
        vecs[5] = '{1, 6'h03, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0, 1'b1, 2};
        vecs[6] = '{0, 6'h13, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 32'd1, 1'b0, MULT_LAT};

        // Reset, with both requesters already waiting for the tie sequence.
        idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        set_req(0, 1'b1, 6'h00, 32'hF0, 32'h0F);
        set_req(1, 1'b1, 6'h01, 32'hF0, 32'h0F);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
        chk("rst_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        chk("rst_rsp", rsp_word(), '0);
        chk("rst_alu", {bus.alu_ctrl, bus.alu_a, bus.alu_b}, '0);
        chk("rst_state", dbg_state, ST_IDLE);

        // Tie from reset: req0, then req1, then a fresh tie goes to req0.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("tie1_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
        wait_rsp(0, lat);
        chk("tie1_latency", lat, 2);
        chk("tie1_other", rv(1), 1'b0);
        chk("tie1_result", rsp_word(), {1'b1, 32'd0, 32'd0});
        consume(0);
        chk("tie2_ready", {bus.req1_ready, bus.req0_ready}, 2'b10);
        wait_rsp(1, lat);
        chk("tie2_result", rsp_word(), {1'b0, 32'd0, 32'hFF});
        consume(1);
        @(negedge clk);
        set_req(0, 1'b1, 6'h03, 32'd1, 32'd2);
        set_req(1, 1'b1, 6'h03, 32'd3, 32'd4);
        #1;
        chk("tie3_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
        wait_rsp(0, lat);
        chk("tie3_result", rsp_word(), {1'b0, 32'd0, 32'd3});
        consume(0);
        chk("tie4_ready", {bus.req1_ready, bus.req0_ready}, 2'b10);
        wait_rsp(1, lat);
        chk("tie4_result", rsp_word(), {1'b0, 32'd0, 32'd7});
        consume(1);

        for (int i = 0; i < 7; i++) single_op(vecs[i], i);

        // Backpressure on requester 1 while requester 0 waits; stray rsp0_ready ignored.
        @(negedge clk);
        set_req(1, 1'b1, 6'h03, 32'd100, 32'd23);
        #1;
        chk("bp_ready", {bus.req1_ready, bus.req0_ready}, 2'b10);
        wait_rsp(1, lat);
        chk("bp_latency", lat, 2);
        chk("bp_result", rsp_word(), {1'b0, 32'd0, 32'd123});
        set_req(0, 1'b1, 6'h01, 32'h0F00, 32'h00F0);
        set_rsp_rdy(0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp_hold%0d", k),
                {bus.rsp1_valid, bus.rsp0_valid, bus.req1_ready, bus.req0_ready, rsp_word()},
                {4'b1000, 1'b0, 32'd0, 32'd123});
        end
        set_rsp_rdy(0, 1'b0);
        set_rsp_rdy(1, 1'b1);
        chk("bp_release_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
        @(negedge clk);
        set_rsp_rdy(1, 1'b0);
        #1;
        chk("bp_req0_grant", {bus.req1_ready, bus.req0_ready, bus.rsp1_valid}, 3'b010);
        wait_rsp(0, lat);
        chk("bp_req0_result", rsp_word(), {1'b0, 32'd0, 32'hFF0});
        consume(0);

        // Reset in the middle of EXEC discards the operation.
        @(negedge clk);
        set_req(0, 1'b1, 6'h02, 32'd3, 32'd5);
        #1;
        chk("rx_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, '0);
        #1;
        chk("rx_exec", {dbg_state, bus.alu_ctrl, bus.alu_a, bus.alu_b},
            {ST_EXEC, 6'h02, 32'd3, 32'd5});
        rst = 1'b0;
        #1;
        chk("rx_rst_out", {bus.req1_ready, bus.req0_ready, bus.rsp1_valid, bus.rsp0_valid,
                           bus.alu_ctrl, bus.alu_a, bus.alu_b}, '0);
        chk("rx_rst_rsp", rsp_word(), '0);
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            seen = seen | bus.rsp0_valid | bus.rsp1_valid | bus.req0_ready | bus.req1_ready;
        end
        chk("rx_no_rsp", seen, 1'b0);

        // Fresh reset so the random model starts from a known pointer.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_random(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
